ppu_tile_shifter: RTL
=====================

# ppu_tile_shifter

Multi-channel background pixel shifter for the PPU render pipeline. It holds CHANNELS parallel shift registers, normally pattern low, pattern high, attribute low and attribute high. Each register loads a new tile byte into its low half and shifts MSB-first once per pixel clock. One bit per channel is selected by the fine-X scroll value. The block also tracks the tile phase, flags when a reload is due, signals when the pipeline is primed, and latches a sticky error if a tile boundary is crossed without a reload.

## Interface
Parameters:
- CHANNELS, default 4: number of parallel shift registers.
- LOAD_WIDTH, default 8: bits loaded per channel per tile; must be a power of two and ≥2.
- WIDTH, default 16: bits per channel register; must be ≥ 2*LOAD_WIDTH.

Ports:
- clk, input, 1: pixel clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- shift_en, input, 1: shift every channel left by one this cycle.
- load, input, 1: load load_data into the low LOAD_WIDTH bits of every channel.
- load_data, input, CHANNELS*LOAD_WIDTH: channel c occupies bits [c*LOAD_WIDTH +: LOAD_WIDTH].
- clr_err, input, 1: clears underrun.
- fine_x, input, $clog2(LOAD_WIDTH): pixel tap select.
- pix_out, output, CHANNELS: bit c = channel c register bit [WIDTH-1-fine_x]; combinational.
- phase, output, $clog2(LOAD_WIDTH): shifts since the last load, modulo LOAD_WIDTH.
- reload_due, output, 1: high when phase == LOAD_WIDTH-1; combinational from phase.
- primed, output, 1: high once at least 2 loads have occurred since reset.
- underrun, output, 1: sticky tile-boundary error.

Reset is synchronous and active-high. The clock is clk and the reset is reset.

## Operation
Per-channel register update, with priority in this order:
- reset: all registers = 0.
- shift_en and load: register = {reg[WIDTH-2:0], 0}, then the low LOAD_WIDTH bits are replaced by the channel's load_data. The shift and the load are applied in the same edge.
- load only: the low LOAD_WIDTH bits are replaced; the upper bits are unchanged.
- shift_en only: reg = {reg[WIDTH-2:0], 0}.
- neither: hold.

Phase counter:
- Reset value 0.
- Any load (with or without shift) sets phase to 0.
- shift_en without load increments phase, wrapping from LOAD_WIDTH-1 to 0.
- Otherwise phase holds.

Load count:
- Internal 2-bit counter that saturates at 2.
- Reset value 0; increments on each load edge.
- primed = (count == 2).

Underrun:
- Set when shift_en=1, load=0 and phase == LOAD_WIDTH-1 in the same cycle, i.e. a tile boundary is crossed without a reload.
- Cleared by reset or clr_err.
- If clr_err and a set condition occur in the same cycle, set wins (underrun = 1).

Reset values: pix_out 0, phase 0, reload_due 0, primed 0, underrun 0.

Data in the upper half of a register only arrives there by shifting. Normal usage is 8 shifts per load, which moves each loaded byte from the low half into the upper half (the visible tap region) one tile ahead.

## Timing
- Registers, phase, load count and underrun update on the rising clk edge.
- pix_out and reload_due are combinational from registered state plus fine_x. There is zero-cycle latency from a fine_x change to pix_out.
- Latency from load to visibility: a byte loaded at edge N reaches tap fine_x=0 (bit WIDTH-1) after WIDTH-LOAD_WIDTH further shift edges. With the defaults that is 8 shifts.
- Back-to-back loads on consecutive cycles are legal; the last one wins for the low half, and each load increments the load count.
- Reset asserted mid-tile clears everything on the next edge, regardless of shift_en, load or clr_err.
- When shift_en and load are both high, phase goes to 0, not 1.

## Test plan
- Reset, then load ch0=0xA5 and all other channels 0. Shift 8 times, load 0x00, then step fine_x from 0 to 7. Required: pix_out[0] sequence 1,0,1,0,0,1,0,1; phase=0; primed=1 after the second load.
- Load 0xFF, shift 7 times. Required: reload_due=1 and phase=7. Then one shift with load=0. Required: underrun=1 and phase=0. Then clr_err. Required: underrun=0 on the next edge.
- Drive shift_en and load together with load_data ch1=0x3C, while the register holds 0x00FF. Required: ch1 register = 0x013C (0x01FE shifted, low byte replaced) and phase=0.
- Assert clr_err in the same cycle as an underrun condition. Required: underrun stays 1.
- Assert reset for one cycle in the middle of a tile at phase=4 with shift_en=1. Required: all outputs 0 and primed=0 on the next edge; normal operation resumes afterwards.
- Parameter sweep with CHANNELS=2, LOAD_WIDTH=4, WIDTH=8. Load 0x9, shift 4 times, load 0. Required: pix_out[0] at fine_x 0..3 = 1,0,0,1; reload_due asserted at phase 3.

Source files
------------

// File: rtl/ppu_tile_shifter.sv
// Background pixel shifter: CHANNELS parallel tile shift registers with fine-X tap,
// tile phase tracking, reload-due flag, priming indicator and sticky underrun error.
module ppu_tile_shifter #(
    parameter int CHANNELS   = 4,
    parameter int LOAD_WIDTH = 8,
    parameter int WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              shift_en,
    input  logic                              load,
    input  logic [CHANNELS*LOAD_WIDTH-1:0]    load_data,
    input  logic                              clr_err,
    input  logic [$clog2(LOAD_WIDTH)-1:0]     fine_x,
    output logic [CHANNELS-1:0]               pix_out,
    output logic [$clog2(LOAD_WIDTH)-1:0]     phase,
    output logic                              reload_due,
    output logic                              primed,
    output logic                              underrun
);

    localparam int PW = $clog2(LOAD_WIDTH);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg_q [CHANNELS];
    logic [WIDTH-1:0] sreg_d [CHANNELS];
    logic [PW-1:0]    phase_q, phase_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             boundary;
    logic [IW-1:0]    tap;

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sreg_d[c] = sreg_q[c];
            if (shift_en) sreg_d[c] = {sreg_q[c][WIDTH-2:0], 1'b0};
            // load overlays the low half after any shift in the same edge
            if (load) sreg_d[c][LOAD_WIDTH-1:0] = load_data[c*LOAD_WIDTH +: LOAD_WIDTH];
        end
    end

    always_comb begin
        boundary = shift_en && !load && (phase_q == PW'(LOAD_WIDTH - 1));
        phase_d  = phase_q;
        if (load)          phase_d = '0;
        else if (shift_en) phase_d = phase_q + PW'(1);
        cnt_d = cnt_q;
        if (load && cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
        err_d = boundary || (err_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) sreg_q[c] <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) sreg_q[c] <= sreg_d[c];
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        tap = IW'(WIDTH - 1) - IW'(fine_x);
        for (int unsigned c = 0; c < CHANNELS; c++) pix_out[c] = sreg_q[c][tap];
    end

    assign phase      = phase_q;
    assign reload_due = (phase_q == PW'(LOAD_WIDTH - 1));
    assign primed     = (cnt_q == 2'd2);
    assign underrun   = err_q;

endmodule
